// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine that owns the HI/LO
// registers. MTHI/MTLO write HI/LO directly at accept. Mul/div run 32
// iterations (shift-add or restoring divide) and then a sign-fixup/write cycle.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE without flush)
//   req_op[2:0]           0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6/7 no-op
//   req_a, req_b          rs / rt operands
//   flush                 abort in-flight op, suppress write and done
//   busy                  state != IDLE
//   done                  one-cycle pulse when HI/LO take a mul/div result
//   hi, lo                architectural HI/LO
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc;     // mul: {partial product, multiplier}; div: {rem, quotient}
  logic [31:0] opnd;    // mul: multiplicand magnitude; div: divisor magnitude
  logic [31:0] a_raw;   // original dividend, returned in HI on divide-by-zero
  logic        is_div, neg_res, neg_rem, dz;

  logic        accept, sgnd;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, rem_sh;
  logic [31:0] diff;
  logic        ge;
  logic [63:0] mul_step, div_step;

  assign req_ready = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign sgnd      = !req_op[0];  // MULT and DIV are the signed forms

  assign a_mag = (sgnd && req_a[31]) ? (32'd0 - req_a) : req_a;
  assign b_mag = (sgnd && req_b[31]) ? (32'd0 - req_b) : req_b;

  // Shift-add: add multiplicand into the upper half when the multiplier LSB
  // (acc[0]) is set, then shift the whole 65-bit value right by one.
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
  assign mul_step = {mul_sum, acc[31:1]};

  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The difference fits in 32 bits when used.
  assign rem_sh   = {acc[63:32], acc[31]};
  assign ge       = rem_sh >= {1'b0, opnd};
  assign diff     = rem_sh[31:0] - opnd;
  assign div_step = {(ge ? diff : rem_sh[31:0]), acc[30:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !req_op[2]) state_nx = RUN;
      RUN:     if (cnt == 5'd0) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      a_raw   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!flush) begin
        case (state)
          IDLE: if (accept) begin
            case (req_op)
              3'd4: hi <= req_a;
              3'd5: lo <= req_a;
              3'd0, 3'd1, 3'd2, 3'd3: begin
                cnt     <= 5'd31;
                is_div  <= req_op[1];
                opnd    <= req_op[1] ? b_mag : a_mag;
                acc     <= {32'd0, (req_op[1] ? a_mag : b_mag)};
                neg_res <= sgnd && (req_a[31] ^ req_b[31]);
                neg_rem <= sgnd && req_a[31];
                dz      <= (req_b == 32'd0);
                a_raw   <= req_a;
              end
              default: ;
            endcase
          end
          RUN: begin
            cnt <= cnt - 5'd1;
            acc <= is_div ? div_step : mul_step;
          end
          FIN: begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= neg_res ? (64'd0 - acc) : acc;
            end else if (dz) begin
              lo <= 32'hFFFF_FFFF;
              hi <= a_raw;
            end else begin
              lo <= neg_res ? (32'd0 - acc[31:0])  : acc[31:0];
              hi <= neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
